score_renderer: RTL

//  Requesting side of the score-digit sprite ROM interface. Holds both players' scores.

---
 rtl/pong_gui_pkg.sv | 21 ++
 rtl/score_renderer_if.sv | 26 ++
 rtl/score_renderer_score_counter.sv | 39 +++
 rtl/score_renderer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pong_gui_pkg.sv
// Shared types and constants for the pong GUI score overlay: sprite geometry,
// pixel/coordinate types and a span helper used by the window tests.
package pong_gui_pkg;

  localparam int DIGIT_W = 11;
  localparam int DIGIT_H = 16;
  localparam int SCORE_W = 4;
  localparam int COORD_W = 10;

  typedef logic [2:0]         rgb_t;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [SCORE_W-1:0] score_t;

  localparam rgb_t RGB_BLACK = 3'b000;

  // Half-open interval test lo <= v < hi.
  function automatic logic in_span(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/score_renderer_if.sv
// Pixel stream in, digit-ROM request/response and composited pixel out.
// master = the renderer (requesting side), slave = the video/ROM environment.
interface score_renderer_if;
  import pong_gui_pkg::*;

  logic   pixel_valid;
  coord_t pixel_row;
  coord_t pixel_col;
  rgb_t   digit_rgb;
  coord_t digit_row;
  coord_t digit_col;
  score_t digit_sel;
  rgb_t   rgb_out;
  logic   rgb_valid;

  modport master (
    input  pixel_valid, pixel_row, pixel_col, digit_rgb,
    output digit_row, digit_col, digit_sel, rgb_out, rgb_valid
  );

  modport slave (
    output pixel_valid, pixel_row, pixel_col, digit_rgb,
    input  digit_row, digit_col, digit_sel, rgb_out, rgb_valid
  );

endinterface

// File: rtl/score_renderer_score_counter.sv
// One player's saturating score counter; clear wins over a point, and points
// are ignored while the game is held over.
module score_counter
  import pong_gui_pkg::*;
#(
  parameter int MAX_SCORE = 9
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   point,
  input  logic   clear,
  input  logic   hold,
  output score_t score,
  output logic   win
);

  score_t score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (clear) begin
      score_d = '0;
    end else if (point && !hold && (score_q < score_t'(MAX_SCORE))) begin
      score_d = score_q + score_t'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
  assign win   = (score_q == score_t'(MAX_SCORE));

endmodule

// File: rtl/score_renderer.sv
// Score overlay: keeps both scores, freezes the shown digits per frame, maps the
// pixel stream onto digit-ROM requests and registers the ROM answer back out.
module score_renderer
  import pong_gui_pkg::*;
#(
  parameter int SCALE_LOG2 = 1,
  parameter int LEFT_X     = 256,
  parameter int RIGHT_X    = 352,
  parameter int TOP_Y      = 32,
  parameter int MAX_SCORE  = 9
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   point_left,
  input  logic   point_right,
  input  logic   clear_scores,
  input  logic   frame_start,
  score_renderer_if.master pix,
  output score_t score_left,
  output score_t score_right,
  output logic   game_over
);

  localparam int SW = DIGIT_W << SCALE_LOG2;
  localparam int SH = DIGIT_H << SCALE_LOG2;
  localparam int WIN_X [2] = '{LEFT_X, RIGHT_X};

  localparam coord_t TOP_LO   = coord_t'(TOP_Y);
  localparam coord_t TOP_HI   = coord_t'(TOP_Y + SH);
  localparam coord_t ROW_IDLE = coord_t'(DIGIT_H);
  localparam coord_t COL_IDLE = coord_t'(DIGIT_W);

  // Index 0 = left player, 1 = right player throughout.
  logic [1:0] point_vec;
  logic [1:0] win_vec;
  score_t     score_vec [2];
  score_t     shown_q   [2];
  score_t     shown_d   [2];

  logic game_over_q, game_over_d;

  assign point_vec = {point_right, point_left};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_player
      score_counter #(
        .MAX_SCORE (MAX_SCORE)
      ) u_counter (
        .clock (clock),
        .reset (reset),
        .point (point_vec[gi]),
        .clear (clear_scores),
        .hold  (game_over_q),
        .score (score_vec[gi]),
        .win   (win_vec[gi])
      );

      // The frame_start sample sees the pre-increment value of a coincident point.
      always_comb begin
        shown_d[gi] = shown_q[gi];
        if (frame_start) begin
          shown_d[gi] = score_vec[gi];
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          shown_q[gi] <= '0;
        end else begin
          shown_q[gi] <= shown_d[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    game_over_d = |win_vec;
    if (clear_scores) begin
      game_over_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      game_over_q <= 1'b0;
    end else begin
      game_over_q <= game_over_d;
    end
  end

  assign score_left  = score_vec[0];
  assign score_right = score_vec[1];
  assign game_over   = game_over_q;

  // Window tests; offsets are only formed when the bound holds, so they never wrap.
  logic       in_rows;
  coord_t     row_off;
  logic [1:0] hit_side;
  coord_t     col_off [2];

  assign in_rows = in_span(pix.pixel_row, TOP_LO, TOP_HI);
  assign row_off = in_rows ? (pix.pixel_row - TOP_LO) : '0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_window
      localparam coord_t X_LO = coord_t'(WIN_X[gi]);
      localparam coord_t X_HI = coord_t'(WIN_X[gi] + SW);

      assign hit_side[gi] = pix.pixel_valid && in_rows &&
                            in_span(pix.pixel_col, X_LO, X_HI);
      assign col_off[gi]  = hit_side[gi] ? (pix.pixel_col - X_LO) : '0;
    end
  endgenerate

  coord_t digit_row_q, digit_row_d;
  coord_t digit_col_q, digit_col_d;
  score_t digit_sel_q, digit_sel_d;
  logic   hit1_q, hit1_d;
  logic   valid1_q, valid1_d;

  always_comb begin
    digit_row_d = ROW_IDLE;
    digit_col_d = COL_IDLE;
    digit_sel_d = '0;
    hit1_d      = 1'b0;
    valid1_d    = pix.pixel_valid;
    if (hit_side[0]) begin
      digit_row_d = row_off >> SCALE_LOG2;
      digit_col_d = col_off[0] >> SCALE_LOG2;
      digit_sel_d = shown_q[0];
      hit1_d      = 1'b1;
    end else if (hit_side[1]) begin
      digit_row_d = row_off >> SCALE_LOG2;
      digit_col_d = col_off[1] >> SCALE_LOG2;
      digit_sel_d = shown_q[1];
      hit1_d      = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      digit_row_q <= ROW_IDLE;
      digit_col_q <= COL_IDLE;
      digit_sel_q <= '0;
      hit1_q      <= 1'b0;
      valid1_q    <= 1'b0;
    end else begin
      digit_row_q <= digit_row_d;
      digit_col_q <= digit_col_d;
      digit_sel_q <= digit_sel_d;
      hit1_q      <= hit1_d;
      valid1_q    <= valid1_d;
    end
  end

  assign pix.digit_row = digit_row_q;
  assign pix.digit_col = digit_col_q;
  assign pix.digit_sel = digit_sel_q;

  rgb_t rgb_q, rgb_d;
  logic rgb_valid_q, rgb_valid_d;

  always_comb begin
    rgb_d       = hit1_q ? pix.digit_rgb : RGB_BLACK;
    rgb_valid_d = valid1_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rgb_q       <= RGB_BLACK;
      rgb_valid_q <= 1'b0;
    end else begin
      rgb_q       <= rgb_d;
      rgb_valid_q <= rgb_valid_d;
    end
  end

  assign pix.rgb_out   = rgb_q;
  assign pix.rgb_valid = rgb_valid_q;

endmodule
